hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Parametrised successor to the datapath hazard unit. Handles RAW stall detection for NUM_SRC decode-stage sources and operand-forwarding selects for NUM_SRC execute-stage sources.
- Sequences multi-cycle branch flushes, freezes the pipeline on data-memory wait, and keeps saturating performance counters.
- Sits between the pipeline registers and the datapath control, with one instance per core.

Parameters:
- REG_W, 5, register index width.
- NUM_SRC, 2, source operands checked per instruction (1..4).
- FWD_EN, 1. 1 = forwarding enabled. 0 = every RAW hazard against EX/MEM writers stalls, and fwd_sel is held at 0.
- FLUSH_CYC, 1, cycles flush_fd/flush_de stay asserted per taken branch (1..7).
- CNT_W, 16, performance counter width.

Ports:
- CLK, in, 1, clock.
- nRST, in, 1, synchronous active-low reset.
- rsel_dec, in, NUM_SRC*REG_W, decode-stage source indices; source i occupies [i*REG_W +: REG_W].
- rvld_dec, in, NUM_SRC, per-source valid.
- rsel_ex, in, NUM_SRC*REG_W, execute-stage source indices, used for forwarding.
- wsel_ex, in, REG_W, EX-stage destination.
- wen_ex, in, 1, EX-stage write enable.
- memread_ex, in, 1, EX instruction is a load.
- wsel_mem, in, REG_W, MEM-stage destination.
- wen_mem, in, 1, MEM-stage write enable.
- memread_mem, in, 1, MEM instruction is a load.
- wsel_wb, in, REG_W, WB-stage destination.
- wen_wb, in, 1, WB-stage write enable.
- dmemreq, in, 1, MEM stage has an outstanding data request.
- dhit, in, 1, data request completes this cycle.
- branch_taken, in, 1, taken branch or jump resolved in EX.
- clr_cnt, in, 1, synchronous counter clear.
- stall_fd, out, 1, hold the IF/ID register.
- stall_de, out, 1, hold the ID/EX register.
- bubble_ex, out, 1, load a NOP into ID/EX.
- freeze, out, 1, hold all pipeline registers.
- flush_fd, out, 1, zero the IF/ID register.
- flush_de, out, 1, zero the ID/EX register.
- fwd_sel, out, 2*NUM_SRC, per-source select: 00 = register file, 01 = MEM result, 10 = WB result.
- stall_cnt, out, CNT_W, cycles with stall_fd=1.
- flush_cnt, out, CNT_W, taken branches accepted.

Behaviour:
- Match rule: a match exists when the writer's wen=1, its wsel equals the source index, the wsel is not 0, and rvld=1 where applicable. Register 0 never matches.
- freeze is combinational: freeze = dmemreq & ~dhit. While freeze=1:
  - stall_fd=stall_de=1, bubble_ex=0, flush_*=0.
  - The FSM and flush counter hold.
  - branch_taken is ignored; it stays asserted because EX is frozen.
- Load-use hazard (luh): memread_ex and a match between wsel_ex and any decode source.
- If FWD_EN=0, additionally: any match between wsel_ex or wsel_mem and a decode source.
- On luh with no freeze and FSM in IDLE: stall_fd=stall_de=1 and bubble_ex=1. This holds combinationally until the hazard clears.
- FSM states: IDLE, FLUSH.
  - IDLE to FLUSH: branch_taken=1 and freeze=0. flush_fd=flush_de=1 in that same cycle. The flush counter loads FLUSH_CYC-1. flush_cnt increments.
  - If FLUSH_CYC=1, the FSM stays in IDLE after that single cycle.
  - FLUSH: flush_fd=flush_de=1 each cycle. The counter decrements. When the counter reaches 0 the flush ends and the FSM returns to IDLE.
  - A branch_taken arriving during FLUSH is ignored.
- Priority: freeze > flush > load-use stall. When flush is active, stall_fd=stall_de=bubble_ex=0.
- Forwarding per EX source i (FWD_EN=1; rvld is not checked):
  - 01 if it matches wen_mem/wsel_mem and memread_mem=0.
  - Otherwise 10 if it matches wen_wb/wsel_wb.
  - Otherwise 00.
  - A MEM match outranks a WB match. A MEM-stage load match yields 10 only if WB also matches, otherwise 00 (this case is excluded by the load-use stall).
  - fwd_sel is combinational and valid during freeze.
- Counters are saturating at all-ones.
  - stall_cnt increments each cycle stall_fd=1, freeze included.
  - clr_cnt outranks increment; the counter reads 0 on the next cycle.
- Reset (nRST=0 at a CLK edge): FSM goes to IDLE, flush counter=0, stall_cnt=flush_cnt=0. All combinational outputs are computed from the reset state. Reset during FLUSH aborts the flush on the next cycle.

Test Plan:
- Load-use: memread_ex=1, wen_ex=1, wsel_ex=5, rsel_dec source 1=5, rvld=11 → stall_fd=stall_de=bubble_ex=1 for one cycle. memread_ex=0 next cycle → all 0. stall_cnt=1.
- Register 0: wsel_ex=0, memread_ex=1, source=0 → no stall. wsel_mem=0 with rsel_ex=0 → fwd_sel=00.
- Forward priority: wsel_mem=wsel_wb=8, both wen=1, rsel_ex source 0=8 → fwd_sel[1:0]=01. Set wen_mem=0 → 10.
- Flush: FLUSH_CYC=3, branch_taken pulse → flush_fd=flush_de=1 for exactly 3 cycles. A second branch_taken in cycle 2 is ignored. flush_cnt=1.
- Freeze: dmemreq=1, dhit=0 for 4 cycles while branch_taken=1 → freeze=1 and no flush. dhit=1 → flush starts that cycle. stall_cnt=4.
- Saturation and reset: CNT_W=4, 20 stall cycles → stall_cnt=15. nRST=0 mid-flush → IDLE and counters 0 next cycle. clr_cnt clears stall_cnt.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control for one in-order core.
// Detects decode-stage RAW stalls, selects execute-stage forwarding paths,
// sequences multi-cycle branch flushes, freezes on data-memory wait, and
// keeps saturating stall/flush counters.
module hazard_forward_unit #(
    parameter int REG_W     = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_EN    = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NUM_SRC*REG_W-1:0]   rsel_dec,
    input  logic [NUM_SRC-1:0]         rvld_dec,
    input  logic [NUM_SRC*REG_W-1:0]   rsel_ex,
    input  logic [REG_W-1:0]           wsel_ex,
    input  logic                       wen_ex,
    input  logic                       memread_ex,
    input  logic [REG_W-1:0]           wsel_mem,
    input  logic                       wen_mem,
    input  logic                       memread_mem,
    input  logic [REG_W-1:0]           wsel_wb,
    input  logic                       wen_wb,
    input  logic                       dmemreq,
    input  logic                       dhit,
    input  logic                       branch_taken,
    input  logic                       clr_cnt,
    output logic                       stall_fd,
    output logic                       stall_de,
    output logic                       bubble_ex,
    output logic                       freeze,
    output logic                       flush_fd,
    output logic                       flush_de,
    output logic [2*NUM_SRC-1:0]       fwd_sel,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [REG_W-1:0] REG_ZERO   = {REG_W{1'b0}};

    state_t           state_q;
    logic [2:0]       fcnt_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic luh;
    logic accept;
    logic flush_active;
    logic hold_luh;

    // Decode-stage RAW detection; without forwarding every EX/MEM writer match stalls.
    always_comb begin
        luh = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rvld_dec[i] && (rsel_dec[i*REG_W +: REG_W] != REG_ZERO)) begin
                if (wen_ex && (wsel_ex == rsel_dec[i*REG_W +: REG_W]) &&
                    (memread_ex || (FWD_EN == 0))) begin
                    luh = 1'b1;
                end
                if ((FWD_EN == 0) && wen_mem && (wsel_mem == rsel_dec[i*REG_W +: REG_W])) begin
                    luh = 1'b1;
                end
            end
        end
    end

    // Per-source forwarding select: MEM (non-load) outranks WB, register 0 never forwards.
    always_comb begin
        fwd_sel = '0;
        if (FWD_EN != 0) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if ((rsel_ex[i*REG_W +: REG_W] != REG_ZERO) && wen_mem && !memread_mem &&
                    (wsel_mem == rsel_ex[i*REG_W +: REG_W])) begin
                    fwd_sel[2*i +: 2] = 2'b01;
                end else if ((rsel_ex[i*REG_W +: REG_W] != REG_ZERO) && wen_wb &&
                             (wsel_wb == rsel_ex[i*REG_W +: REG_W])) begin
                    fwd_sel[2*i +: 2] = 2'b10;
                end
            end
        end
    end

    // Control outputs with priority freeze > flush > load-use stall.
    always_comb begin
        freeze       = dmemreq & ~dhit;
        accept       = ~freeze & (state_q == IDLE) & branch_taken;
        flush_active = ~freeze & ((state_q == FLUSH) | accept);
        hold_luh     = ~freeze & ~flush_active & (state_q == IDLE) & luh;
        stall_fd     = freeze | hold_luh;
        stall_de     = freeze | hold_luh;
        bubble_ex    = hold_luh;
        flush_fd     = flush_active;
        flush_de     = flush_active;
    end

    // Flush sequencer: holds while frozen, ignores branches while already flushing.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            fcnt_q  <= 3'd0;
        end else if (!freeze) begin
            case (state_q)
                IDLE: begin
                    if (branch_taken && (FLUSH_CYC > 1)) begin
                        state_q <= FLUSH;
                        fcnt_q  <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (fcnt_q <= 3'd1) begin
                        state_q <= IDLE;
                        fcnt_q  <= 3'd0;
                    end else begin
                        fcnt_q  <= fcnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    fcnt_q  <= 3'd0;
                end
            endcase
        end
    end

    // Saturating counter next-state; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_fd && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
            if (accept && (flush_cnt_q != CNT_MAX))   flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: main instance with forwarding, 3-cycle flush
// and 4-bit counters; second instance without forwarding, 1-cycle flush.
module tb_hazard_forward_unit;

    localparam int REG_W   = 5;
    localparam int NUM_SRC = 2;
    localparam int W       = 10;

    // {stall_fd, stall_de, bubble_ex, freeze, flush_fd, flush_de, fwd_sel[3:0]}
    localparam logic [W-1:0] E_NONE = 10'b000000_0000;
    localparam logic [W-1:0] E_LUH  = 10'b111000_0000;
    localparam logic [W-1:0] E_FRZ  = 10'b110100_0000;
    localparam logic [W-1:0] E_FL   = 10'b000011_0000;

    logic                     CLK, nRST;
    logic [NUM_SRC*REG_W-1:0] rsel_dec, rsel_ex;
    logic [NUM_SRC-1:0]       rvld_dec;
    logic [REG_W-1:0]         wsel_ex, wsel_mem, wsel_wb;
    logic wen_ex, memread_ex, wen_mem, memread_mem, wen_wb;
    logic dmemreq, dhit, branch_taken, clr_cnt;

    logic stall_fd, stall_de, bubble_ex, freeze, flush_fd, flush_de;
    logic [2*NUM_SRC-1:0] fwd_sel;
    logic [3:0]           stall_cnt, flush_cnt;

    logic stall_fd0, stall_de0, bubble_ex0, freeze0, flush_fd0, flush_de0;
    logic [2*NUM_SRC-1:0] fwd_sel0;
    logic [15:0]          stall_cnt0, flush_cnt0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q0[$];
    int checks, errors;

    wire [W-1:0] obs  = {stall_fd, stall_de, bubble_ex, freeze, flush_fd, flush_de, fwd_sel};
    wire [W-1:0] obs0 = {stall_fd0, stall_de0, bubble_ex0, freeze0, flush_fd0, flush_de0, fwd_sel0};

    hazard_forward_unit #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .FWD_EN(1), .FLUSH_CYC(3), .CNT_W(4)) u_dut (
        .CLK(CLK), .nRST(nRST), .rsel_dec(rsel_dec), .rvld_dec(rvld_dec), .rsel_ex(rsel_ex),
        .wsel_ex(wsel_ex), .wen_ex(wen_ex), .memread_ex(memread_ex),
        .wsel_mem(wsel_mem), .wen_mem(wen_mem), .memread_mem(memread_mem),
        .wsel_wb(wsel_wb), .wen_wb(wen_wb), .dmemreq(dmemreq), .dhit(dhit),
        .branch_taken(branch_taken), .clr_cnt(clr_cnt),
        .stall_fd(stall_fd), .stall_de(stall_de), .bubble_ex(bubble_ex), .freeze(freeze),
        .flush_fd(flush_fd), .flush_de(flush_de), .fwd_sel(fwd_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_forward_unit #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .FWD_EN(0), .FLUSH_CYC(1), .CNT_W(16)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .rsel_dec(rsel_dec), .rvld_dec(rvld_dec), .rsel_ex(rsel_ex),
        .wsel_ex(wsel_ex), .wen_ex(wen_ex), .memread_ex(memread_ex),
        .wsel_mem(wsel_mem), .wen_mem(wen_mem), .memread_mem(memread_mem),
        .wsel_wb(wsel_wb), .wen_wb(wen_wb), .dmemreq(dmemreq), .dhit(dhit),
        .branch_taken(branch_taken), .clr_cnt(clr_cnt),
        .stall_fd(stall_fd0), .stall_de(stall_de0), .bubble_ex(bubble_ex0), .freeze(freeze0),
        .flush_fd(flush_fd0), .flush_de(flush_de0), .fwd_sel(fwd_sel0),
        .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    // Clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_zero();
        rsel_dec = '0; rvld_dec = '0; rsel_ex = '0;
        wsel_ex = '0; wen_ex = 1'b0; memread_ex = 1'b0;
        wsel_mem = '0; wen_mem = 1'b0; memread_mem = 1'b0;
        wsel_wb = '0; wen_wb = 1'b0;
        dmemreq = 1'b0; dhit = 1'b0; branch_taken = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic set_luh();
        memread_ex = 1'b1; wen_ex = 1'b1; wsel_ex = 5'd5;
        rsel_dec = {5'd5, 5'd3}; rvld_dec = 2'b11;
    endtask

    // Driver: inputs already applied at the falling edge; expectations queued,
    // outputs sampled 2 time units later, then advance to the next falling edge.
    task automatic cycle(input string tag, input logic [W-1:0] e,
                         input bit chk0, input logic [W-1:0] e0);
        exp_q.push_back(e);
        if (chk0) exp_q0.push_back(e0);
        #2;
        check_eq(tag, 32'(obs), 32'(exp_q.pop_front()));
        if (chk0) check_eq({tag, "_nofwd"}, 32'(obs0), 32'(exp_q0.pop_front()));
        @(negedge CLK);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        set_zero();
        nRST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        cycle("reset_out", E_NONE, 1, E_NONE);
        check_eq("reset_stall_cnt", 32'(stall_cnt), 0);
        check_eq("reset_flush_cnt", 32'(flush_cnt), 0);
        nRST = 1'b1;

        // Load-use
        set_luh();
        cycle("luh", E_LUH, 1, E_LUH);
        memread_ex = 1'b0;
        cycle("luh_clear", E_NONE, 1, E_LUH);
        check_eq("luh_stall_cnt", 32'(stall_cnt), 1);
        set_luh(); rvld_dec = 2'b01;
        cycle("luh_rvld", E_NONE, 1, E_NONE);
        set_zero(); clr_cnt = 1'b1;
        cycle("clr0", E_NONE, 0, E_NONE);
        clr_cnt = 1'b0;

        // Register 0 never matches
        memread_ex = 1'b1; wen_ex = 1'b1; wsel_ex = '0; rsel_dec = '0; rvld_dec = 2'b11;
        wen_mem = 1'b1; wsel_mem = '0; rsel_ex = '0;
        cycle("reg0", E_NONE, 1, E_NONE);

        // Forwarding priority
        set_zero();
        wen_mem = 1'b1; wsel_mem = 5'd8; wen_wb = 1'b1; wsel_wb = 5'd8;
        rsel_ex = {5'd3, 5'd8};
        cycle("fwd_mem", 10'b000000_0001, 1, E_NONE);
        wen_mem = 1'b0;
        cycle("fwd_wb", 10'b000000_0010, 0, E_NONE);
        wen_mem = 1'b1; memread_mem = 1'b1;
        cycle("fwd_load_wb", 10'b000000_0010, 0, E_NONE);
        wen_wb = 1'b0;
        cycle("fwd_load_none", E_NONE, 0, E_NONE);
        memread_mem = 1'b0; wen_wb = 1'b1; wsel_wb = 5'd9; rsel_ex = {5'd9, 5'd8};
        cycle("fwd_both", 10'b000000_1001, 0, E_NONE);
        set_zero();
        wen_mem = 1'b1; wsel_mem = 5'd8; rsel_dec = {5'd0, 5'd8}; rvld_dec = 2'b01; rsel_ex = {5'd0, 5'd8};
        cycle("nofwd_mem_stall", 10'b000000_0001, 1, E_LUH);

        set_zero(); clr_cnt = 1'b1;
        cycle("clr1", E_NONE, 0, E_NONE);
        clr_cnt = 1'b0;

        // Branch flush, second branch while flushing ignored, flush beats load-use
        branch_taken = 1'b1;
        cycle("flush_c0", E_FL, 1, E_FL);
        branch_taken = 1'b0;
        cycle("flush_c1", E_FL, 1, E_NONE);
        branch_taken = 1'b1; set_luh();
        cycle("flush_c2", E_FL, 1, E_FL);
        set_zero();
        cycle("flush_end", E_NONE, 1, E_NONE);
        check_eq("flush_cnt", 32'(flush_cnt), 1);
        check_eq("flush_cnt_nofwd", 32'(flush_cnt0), 2);
        check_eq("flush_stall_cnt", 32'(stall_cnt), 0);

        // Freeze holds off the branch, then flush starts on dhit
        dmemreq = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) cycle("freeze", E_FRZ, 1, E_FRZ);
        dhit = 1'b1;
        cycle("freeze_release", E_FL, 1, E_FL);
        check_eq("freeze_stall_cnt", 32'(stall_cnt), 4);
        set_zero();
        cycle("frz_flush_c1", E_FL, 0, E_NONE);
        dmemreq = 1'b1;
        cycle("frz_in_flush", E_FRZ, 0, E_NONE);
        dmemreq = 1'b0;
        cycle("frz_flush_c2", E_FL, 0, E_NONE);
        cycle("frz_flush_end", E_NONE, 0, E_NONE);
        check_eq("frz_stall_cnt", 32'(stall_cnt), 5);
        check_eq("frz_flush_cnt", 32'(flush_cnt), 2);

        // Saturation
        clr_cnt = 1'b1;
        cycle("clr2", E_NONE, 0, E_NONE);
        clr_cnt = 1'b0;
        set_luh();
        for (int i = 0; i < 20; i++) cycle("sat_luh", E_LUH, 1, E_LUH);
        set_zero();
        cycle("sat_idle", E_NONE, 0, E_NONE);
        check_eq("sat_stall_cnt", 32'(stall_cnt), 15);
        check_eq("sat_stall_cnt_nofwd", 32'(stall_cnt0), 20);

        // Reset mid-flush
        branch_taken = 1'b1;
        cycle("rf_c0", E_FL, 0, E_NONE);
        branch_taken = 1'b0; nRST = 1'b0;
        cycle("rf_c1", E_FL, 0, E_NONE);
        nRST = 1'b1;
        cycle("rf_aborted", E_NONE, 0, E_NONE);
        check_eq("rf_stall_cnt", 32'(stall_cnt), 0);
        check_eq("rf_flush_cnt", 32'(flush_cnt), 0);

        // Clear beats increment, then plain clear
        set_luh(); clr_cnt = 1'b1;
        cycle("clr_vs_inc", E_LUH, 0, E_NONE);
        set_zero();
        cycle("clr_vs_inc_idle", E_NONE, 0, E_NONE);
        check_eq("clr_vs_inc_cnt", 32'(stall_cnt), 0);
        set_luh();
        cycle("one_stall", E_LUH, 0, E_NONE);
        set_zero();
        cycle("one_stall_idle", E_NONE, 0, E_NONE);
        check_eq("one_stall_cnt", 32'(stall_cnt), 1);
        clr_cnt = 1'b1;
        cycle("clr3", E_NONE, 0, E_NONE);
        clr_cnt = 1'b0;
        check_eq("clr3_cnt", 32'(stall_cnt), 0);

        check_eq("queue_empty", 32'(exp_q.size() + exp_q0.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
